rf_scoreboard: RTL and testbench
================================

RF_SCOREBOARD -- requirements
Module: rf_scoreboard

Interface
REQ-001 SHALL take parameter WORD_WIDTH, default 16, register width in bits.
REQ-002 SHALL take parameter ADDRESS_WIDTH, default 3; UNITS = 2**ADDRESS_WIDTH registers.
REQ-003 SHALL take parameter NUM_RD, default 8, number of read ports.
REQ-004 SHALL take parameter NUM_WR, default 4, number of write ports.
REQ-005 SHALL take parameter IP_OFFSET, default 7, index of the instruction-pointer register.
REQ-006 SHALL take parameter IP_STEP, default 1, auto-increment amount of the instruction pointer.
REQ-007 SHALL take parameter ZERO_R0, default 1, 1 = register 0 hardwired to zero.
REQ-008 SHALL provide ports in this order:
- clk_i  in  1  clock, rising edge.
- arst_i  in  1  reset, asynchronous, active-high.
- rd_sel_i  in  [NUM_RD][ADDRESS_WIDTH]  read addresses.
- rd_data_o  out  [NUM_RD][WORD_WIDTH]  read data.
- rd_ready_o  out  [NUM_RD]  1 = addressed register has no pending reservation.
- wr_sel_i  in  [NUM_WR][ADDRESS_WIDTH]  write addresses.
- wr_data_i  in  [NUM_WR][WORD_WIDTH]  write data.
- wr_en_i  in  [NUM_WR]  per-port write enable.
- rsv_sel_i  in  ADDRESS_WIDTH  register to reserve.
- rsv_en_i  in  1  reservation strobe.
- ip_adv_i  in  1  advance instruction pointer.
- ip_o  out  WORD_WIDTH  current instruction-pointer value.
- pending_o  out  UNITS  per-register pending bits.

Function
REQ-009 SHALL drive rd_data_o[k] combinationally from the registered value at rd_sel_i[k]; writes become visible the cycle after the write edge (no bypass).
REQ-010 SHALL, when several enabled write ports target one register in the same cycle, store the data of the highest-numbered port.
REQ-011 SHALL leave unaddressed registers and registers with no enabled write unchanged.
REQ-012 SHALL, when ZERO_R0 = 1, ignore writes to register 0, read it as 0, and hold pending_o[0] = 0 (reservations of 0 ignored).
REQ-013 SHALL drive ip_o from register IP_OFFSET; that register is also readable and writable through the normal ports.
REQ-014 SHALL, when ip_adv_i = 1 and no enabled write targets IP_OFFSET, update IP to IP + IP_STEP modulo 2**WORD_WIDTH.
REQ-015 SHALL give an explicit write to IP_OFFSET priority over ip_adv_i in the same cycle (written value stored, no increment).
REQ-016 SHALL set pending[rsv_sel_i] at the clock edge when rsv_en_i = 1.
REQ-017 SHALL clear pending[r] at the clock edge when any enabled write targets r and no reservation of r occurs in that cycle.
REQ-018 SHALL keep pending[r] set when a reservation and a write to r coincide (the new reservation wins).
REQ-019 SHALL keep an already-set pending bit set when it is reserved again.
REQ-020 SHALL drive rd_ready_o[k] = ~pending[rd_sel_i[k]] combinationally.
REQ-021 SHALL require IP_OFFSET < UNITS and, when ZERO_R0 = 1, IP_OFFSET != 0, both checked at elaboration.

Reset
REQ-022 SHALL, while arst_i = 1 and independent of clk_i, clear all registers (so ip_o = 0 and rd_data_o = 0) and all pending bits (so rd_ready_o = all ones).
REQ-023 SHALL discard any write, reservation or IP advance coinciding with reset, and resume on the first rising edge after arst_i falls.

Verification
REQ-024 SHALL cover write priority: ports 0 and 3 write r2 with 0x1111 and 0x3333 -> r2 reads 0x3333 next cycle.
REQ-025 SHALL cover R0: write 0xFFFF to r0 and reserve r0 -> r0 reads 0, pending_o[0] = 0.
REQ-026 SHALL cover IP: IP = 0xFFFF with ip_adv_i -> ip_o = 0x0000; port 1 writes 0x0040 to r7 together with ip_adv_i -> ip_o = 0x0040.
REQ-027 SHALL cover scoreboard: reserve r3 -> rd_ready_o = 0 for r3; write r3 -> ready next cycle; reserve and write r3 together -> stays pending, data updated.
REQ-028 SHALL cover reset mid-operation: arst_i pulsed between edges with r5 = 0x00AA and r5 pending -> r5 = 0 and pending_o = 0 immediately, before the next edge.

Source files
------------

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: multi-port register file with per-register pending bits and an
// auto-incrementing instruction-pointer register.
module rf_scoreboard #(
    parameter int WORD_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 3,
    parameter int NUM_RD        = 8,
    parameter int NUM_WR        = 4,
    parameter int IP_OFFSET     = 7,
    parameter int IP_STEP       = 1,
    parameter int ZERO_R0       = 1
) (
    input  logic                                    clk_i,
    input  logic                                    arst_i,
    input  logic [NUM_RD-1:0][ADDRESS_WIDTH-1:0]    rd_sel_i,
    output logic [NUM_RD-1:0][WORD_WIDTH-1:0]       rd_data_o,
    output logic [NUM_RD-1:0]                       rd_ready_o,
    input  logic [NUM_WR-1:0][ADDRESS_WIDTH-1:0]    wr_sel_i,
    input  logic [NUM_WR-1:0][WORD_WIDTH-1:0]       wr_data_i,
    input  logic [NUM_WR-1:0]                       wr_en_i,
    input  logic [ADDRESS_WIDTH-1:0]                rsv_sel_i,
    input  logic                                    rsv_en_i,
    input  logic                                    ip_adv_i,
    output logic [WORD_WIDTH-1:0]                   ip_o,
    output logic [(2**ADDRESS_WIDTH)-1:0]           pending_o
);
    localparam int UNITS = 2**ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] IP_IDX = ADDRESS_WIDTH'(IP_OFFSET);

    if (IP_OFFSET >= UNITS || (ZERO_R0 != 0 && IP_OFFSET == 0)) begin : g_bad_ip
        $error("rf_scoreboard: IP_OFFSET must be < UNITS and nonzero when ZERO_R0");
    end

    logic [UNITS-1:0][WORD_WIDTH-1:0] regs_q, regs_d;
    logic [UNITS-1:0]                 pending_q, pending_d;

    // Later assignments override earlier ones: advance < writes (ascending port) < reservation
    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        if (ip_adv_i)
            regs_d[IP_IDX] = regs_q[IP_IDX] + WORD_WIDTH'(IP_STEP);
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en_i[p]) begin
                regs_d[wr_sel_i[p]]    = wr_data_i[p];
                pending_d[wr_sel_i[p]] = 1'b0;
            end
        end
        if (rsv_en_i)
            pending_d[rsv_sel_i] = 1'b1;
        if (ZERO_R0 != 0) begin
            regs_d[0]    = '0;
            pending_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            regs_q    <= '0;
            pending_q <= '0;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rd_data_o[k]  = regs_q[rd_sel_i[k]];
            rd_ready_o[k] = ~pending_q[rd_sel_i[k]];
        end
    end

    assign ip_o      = regs_q[IP_IDX];
    assign pending_o = pending_q;
endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: table-driven check of rf_scoreboard with an expected-result queue
// plus hand-written reset sequences.
module tb_rf_scoreboard;
    logic                  clk_i = 1'b0;
    logic                  arst_i;
    logic [7:0][2:0]       rd_sel_i;
    logic [7:0][15:0]      rd_data_o;
    logic [7:0]            rd_ready_o;
    logic [3:0][2:0]       wr_sel_i;
    logic [3:0][15:0]      wr_data_i;
    logic [3:0]            wr_en_i;
    logic [2:0]            rsv_sel_i;
    logic                  rsv_en_i;
    logic                  ip_adv_i;
    logic [15:0]           ip_o;
    logic [7:0]            pending_o;

    int checks = 0;
    int errors = 0;

    rf_scoreboard dut (
        .clk_i(clk_i), .arst_i(arst_i),
        .rd_sel_i(rd_sel_i), .rd_data_o(rd_data_o), .rd_ready_o(rd_ready_o),
        .wr_sel_i(wr_sel_i), .wr_data_i(wr_data_i), .wr_en_i(wr_en_i),
        .rsv_sel_i(rsv_sel_i), .rsv_en_i(rsv_en_i), .ip_adv_i(ip_adv_i),
        .ip_o(ip_o), .pending_o(pending_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [2:0]  sel;
        logic [15:0] data;
        logic        ready;
        logic [15:0] ip;
        logic [7:0]  pend;
    } exp_t;

    typedef struct packed {
        logic [3:0]       wen;
        logic [3:0][2:0]  wsel;
        logic [3:0][15:0] wdata;
        logic             rsv;
        logic [2:0]       rs;
        logic             adv;
        exp_t             e;
    } vec_t;

    exp_t exp_q[$];

    function automatic vec_t v(logic [3:0] wen, logic [11:0] wsel, logic [63:0] wdata,
                               logic rsv, logic [2:0] rs, logic adv, logic [2:0] cs,
                               logic [15:0] ed, logic er, logic [15:0] eip, logic [7:0] ep);
        vec_t r;
        r.wen = wen; r.wsel = wsel; r.wdata = wdata;
        r.rsv = rsv; r.rs = rs; r.adv = adv;
        r.e = '{sel: cs, data: ed, ready: er, ip: eip, pend: ep};
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic idle_inputs();
        wr_en_i = '0; wr_sel_i = '0; wr_data_i = '0;
        rsv_en_i = 1'b0; rsv_sel_i = '0; ip_adv_i = 1'b0;
    endtask

    task automatic set_rd(input logic [2:0] s);
        for (int k = 0; k < 8; k++) rd_sel_i[k] = s;
    endtask

    task automatic check_all(input string tag, input exp_t e);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s rd_data[%0d]", tag, k), 32'(rd_data_o[k]), 32'(e.data));
            chk($sformatf("%s rd_ready[%0d]", tag, k), 32'(rd_ready_o[k]), 32'(e.ready));
        end
        chk({tag, " ip"}, 32'(ip_o), 32'(e.ip));
        chk({tag, " pending"}, 32'(pending_o), 32'(e.pend));
    endtask

    task automatic apply(input int idx, input vec_t t);
        exp_t e;
        @(negedge clk_i);
        wr_en_i = t.wen; wr_sel_i = t.wsel; wr_data_i = t.wdata;
        rsv_en_i = t.rsv; rsv_sel_i = t.rs; ip_adv_i = t.adv;
        exp_q.push_back(t.e);
        @(posedge clk_i);
        #1;
        idle_inputs();
        set_rd(t.e.sel);
        #1;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL vec%0d: scoreboard empty", idx);
        end else begin
            e = exp_q.pop_front();
            check_all($sformatf("vec%0d", idx), e);
        end
    endtask

    vec_t tbl[16];

    initial begin
        tbl[0]  = v(4'b1001, {3'd2,3'd0,3'd0,3'd2}, {16'h3333,16'h0,16'h0,16'h1111}, 0,0,0, 3'd2, 16'h3333,1,16'h0000,8'h00);
        tbl[1]  = v(4'b0001, {9'd0,3'd0}, {48'h0,16'hFFFF}, 1,3'd0,0, 3'd0, 16'h0000,1,16'h0000,8'h00);
        tbl[2]  = v(4'b0010, {6'd0,3'd7,3'd0}, {32'h0,16'hFFFF,16'h0}, 0,0,0, 3'd7, 16'hFFFF,1,16'hFFFF,8'h00);
        tbl[3]  = v(4'b0000, 12'd0, 64'd0, 0,0,1, 3'd7, 16'h0000,1,16'h0000,8'h00);
        tbl[4]  = v(4'b0010, {6'd0,3'd7,3'd0}, {32'h0,16'h0040,16'h0}, 0,0,1, 3'd7, 16'h0040,1,16'h0040,8'h00);
        tbl[5]  = v(4'b0000, 12'd0, 64'd0, 0,0,1, 3'd7, 16'h0041,1,16'h0041,8'h00);
        tbl[6]  = v(4'b0000, 12'd0, 64'd0, 1,3'd3,0, 3'd3, 16'h0000,0,16'h0041,8'h08);
        tbl[7]  = v(4'b0100, {3'd0,3'd3,6'd0}, {16'h0,16'hBEEF,32'h0}, 0,0,0, 3'd3, 16'hBEEF,1,16'h0041,8'h00);
        tbl[8]  = v(4'b0001, {9'd0,3'd3}, {48'h0,16'h1234}, 1,3'd3,0, 3'd3, 16'h1234,0,16'h0041,8'h08);
        tbl[9]  = v(4'b0000, 12'd0, 64'd0, 1,3'd3,0, 3'd3, 16'h1234,0,16'h0041,8'h08);
        tbl[10] = v(4'b0000, 12'd0, 64'd0, 1,3'd5,1, 3'd5, 16'h0000,0,16'h0042,8'h28);
        tbl[11] = v(4'b0110, {3'd0,3'd5,3'd6,3'd0}, {16'h0,16'h00AA,16'h5555,16'h0}, 0,0,0, 3'd5, 16'h00AA,1,16'h0042,8'h08);
        tbl[12] = v(4'b1111, {3'd1,3'd1,3'd1,3'd1}, {16'h4,16'h3,16'h2,16'h1}, 0,0,0, 3'd1, 16'h0004,1,16'h0042,8'h08);
        tbl[13] = v(4'b1000, {3'd3,9'd0}, {16'h3,48'h0}, 1,3'd6,0, 3'd6, 16'h5555,0,16'h0042,8'h40);
        tbl[14] = v(4'b0000, 12'd0, 64'd0, 0,0,0, 3'd2, 16'h3333,1,16'h0042,8'h40);
        tbl[15] = v(4'b0001, {9'd0,3'd5}, {48'h0,16'h00AA}, 1,3'd5,0, 3'd5, 16'h00AA,0,16'h0042,8'h60);

        arst_i = 1'b1;
        idle_inputs();
        set_rd(3'd7);
        repeat (2) @(posedge clk_i);
        #1;
        check_all("reset", '{sel: 3'd7, data: 16'h0, ready: 1'b1, ip: 16'h0, pend: 8'h00});
        @(negedge clk_i);
        arst_i = 1'b0;

        for (int i = 0; i < 16; i++) apply(i, tbl[i]);

        // r5 holds 0x00AA and is pending; reset between edges must clear it at once
        #2;
        arst_i = 1'b1;
        #1;
        check_all("midreset", '{sel: 3'd5, data: 16'h0, ready: 1'b1, ip: 16'h0, pend: 8'h00});
        wr_en_i = 4'b0001; wr_sel_i[0] = 3'd4; wr_data_i[0] = 16'h0077;
        rsv_en_i = 1'b1; rsv_sel_i = 3'd4; ip_adv_i = 1'b1;
        set_rd(3'd4);
        @(posedge clk_i);
        #1;
        check_all("inreset", '{sel: 3'd4, data: 16'h0, ready: 1'b1, ip: 16'h0, pend: 8'h00});
        @(negedge clk_i);
        arst_i = 1'b0;
        idle_inputs();
        #1;
        check_all("postreset", '{sel: 3'd4, data: 16'h0, ready: 1'b1, ip: 16'h0, pend: 8'h00});
        apply(16, v(4'b0001, {9'd0,3'd4}, {48'h0,16'h0077}, 0,0,0, 3'd4, 16'h0077,1,16'h0000,8'h00));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
